// File: rtl/bht_dir_predictor.sv
// Direction predictor: tagged table of 2-bit saturating counters, looked up from IF, trained from EX.
// Optional statistics counters are enabled by defining BHT_STATS_EN.
module bht_dir_predictor #(
  parameter int unsigned INDEX_LEN = 6,
  parameter int unsigned TAG_LEN   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_IF,
  output logic        bht_hit,
  output logic [1:0]  bht_pred_br,
  output logic        pred_taken,
  input  logic        update_en,
  input  logic [31:0] PC_EX,
  input  logic        br_taken_EX,
  input  logic        bht_hit_EX,
  input  logic [1:0]  bht_pred_br_EX,
  output logic        bht_mispred,
  output logic [31:0] stat_br_cnt,
  output logic [31:0] stat_mispred_cnt
);

  localparam int unsigned Entries = 1 << INDEX_LEN;
  localparam int unsigned TagLo   = INDEX_LEN + 2;
  localparam int unsigned TagHi   = INDEX_LEN + TAG_LEN + 1;

  logic               valid_q [Entries];
  logic [TAG_LEN-1:0] tag_q   [Entries];
  logic [1:0]         cnt_q   [Entries];

  logic [INDEX_LEN-1:0] idx_if, idx_ex;
  logic [TAG_LEN-1:0]   tag_if, tag_ex;
  logic                 lookup_hit, ex_hit;
  logic [1:0]           cnt_ex, cnt_next;

  assign idx_if = PC_IF[INDEX_LEN+1:2];
  assign tag_if = PC_IF[TagHi:TagLo];
  assign idx_ex = PC_EX[INDEX_LEN+1:2];
  assign tag_ex = PC_EX[TagHi:TagLo];

  // Bits outside index/tag do not participate in prediction.
  logic unused_bits;
  assign unused_bits = ^{PC_IF[31:TagHi+1], PC_IF[1:0], PC_EX[31:TagHi+1], PC_EX[1:0],
                         bht_pred_br_EX[0]};

  // Lookup returns pre-edge contents; no bypass from a coincident update.
  assign lookup_hit  = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
  assign bht_hit     = !rst && lookup_hit;
  assign bht_pred_br = bht_hit ? cnt_q[idx_if] : 2'b00;
  assign pred_taken  = bht_hit & bht_pred_br[1];

  assign bht_mispred = !rst && update_en &&
                       ((bht_hit_EX & bht_pred_br_EX[1]) != br_taken_EX);

  // Training uses the stored counter, not the one carried down the pipe.
  assign ex_hit = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);
  assign cnt_ex = cnt_q[idx_ex];

  always_comb begin
    cnt_next = cnt_ex;
    if (br_taken_EX) begin
      if (cnt_ex != 2'b11) cnt_next = cnt_ex + 2'b01;
    end else begin
      if (cnt_ex != 2'b00) cnt_next = cnt_ex - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= 2'b01;
      end
    end else if (update_en) begin
      if (ex_hit) begin
        cnt_q[idx_ex] <= cnt_next;
      end else if (br_taken_EX) begin
        valid_q[idx_ex] <= 1'b1;
        tag_q[idx_ex]   <= tag_ex;
        cnt_q[idx_ex]   <= 2'b10;
      end
    end
  end

`ifdef BHT_STATS_EN
  logic [31:0] br_cnt_q, mis_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q  <= 32'd0;
      mis_cnt_q <= 32'd0;
    end else if (update_en) begin
      if (br_cnt_q != 32'hFFFF_FFFF) br_cnt_q <= br_cnt_q + 32'd1;
      if (bht_mispred && (mis_cnt_q != 32'hFFFF_FFFF)) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign stat_br_cnt      = br_cnt_q;
  assign stat_mispred_cnt = mis_cnt_q;
`else
  assign stat_br_cnt      = 32'd0;
  assign stat_mispred_cnt = 32'd0;
`endif

endmodule

// File: doc/bht_dir_predictor.md
# bht_dir_predictor

Branch history table (BHT) that produces the `bht_hit` / `bht_pred_br` pair for the fetching PC in IF. It also consumes the same pair after the pipeline carries it to EX, together with the resolved branch outcome, to train its 2-bit saturating counters. It sits beside the BTB in the IF stage. Its outputs feed the IF/ID and ID/EX prediction registers; its update port is driven from EX.

## Interface
- `INDEX_LEN`, 6: index bits taken from `PC[INDEX_LEN+1:2]`; table has 2^INDEX_LEN entries.
- `TAG_LEN`, 8: tag bits taken from `PC[INDEX_LEN+TAG_LEN+1:INDEX_LEN+2]`.
- `clk`  in  1  clock; all state changes on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `PC_IF`  in  32  lookup address.
- `bht_hit`  out  1  valid entry with matching tag at `PC_IF`.
- `bht_pred_br`  out  2  counter of the hit entry; 2'b00 on miss.
- `pred_taken`  out  1  `bht_hit & bht_pred_br[1]`.
- `update_en`  in  1  a branch instruction is resolved in EX this cycle.
- `PC_EX`  in  32  address of the resolving branch.
- `br_taken_EX`  in  1  actual outcome.
- `bht_hit_EX`  in  1  `bht_hit` captured at lookup and carried to EX.
- `bht_pred_br_EX`  in  2  `bht_pred_br` captured at lookup and carried to EX.
- `bht_mispred`  out  1  direction mispredict flag for the EX branch.
- `stat_br_cnt`  out  32  resolved branch count.
- `stat_mispred_cnt`  out  32  mispredict count.

## Operation
- Each entry holds `valid`, `tag[TAG_LEN-1:0]` and `cnt[1:0]` (00 strongly not taken, 01 weakly not taken, 10 weakly taken, 11 strongly taken).
- Lookup is combinational:
  - `bht_hit = valid[idx] && tag[idx]==tagIF`.
  - `bht_pred_br = bht_hit ? cnt[idx] : 2'b00`.
- `bht_mispred = update_en && ((bht_hit_EX & bht_pred_br_EX[1]) != br_taken_EX)`. It is combinational and is 0 when `update_en`=0.
- Update at posedge when `update_en`=1, at entry `idxEX`:
  - Entry valid and tag matches: the stored `cnt` saturates by ±1. Increment if taken, decrement if not. 11+1 stays 11; 00-1 stays 00.
    - The stored value is used, not `bht_pred_br_EX`, because intervening updates may have changed it.
  - Miss and taken: allocate. Set `valid`=1, `tag`=tagEX, `cnt`=2'b10.
  - Miss and not taken: no change; no allocation.
- `bht_hit_EX`/`bht_pred_br_EX` are used only for `bht_mispred`; they never select the write path.
- Simultaneous lookup and update at the same index: lookup returns the pre-edge contents (no bypass). The new value is visible the cycle after the edge.
- Reset (`rst`=1 at posedge):
  - All `valid` cleared, all `cnt`=2'b01, statistic counters cleared.
  - While `rst` is high, `bht_hit`=0, `bht_pred_br`=2'b00, `pred_taken`=0, `bht_mispred`=0.
  - `rst` wins over a coincident `update_en`.

## Timing
- Lookup latency: 0 cycles (same-cycle combinational from `PC_IF`).
- Update latency: 1 edge. A lookup in the cycle after the update edge observes it.
- Flushed or bubbled EX instructions must arrive with `update_en`=0. The block does not qualify `update_en` itself.
- Back-to-back updates to the same entry on consecutive cycles each apply ±1 in order.
- Reset values after the first `rst` edge: table empty, both stat counters 0.

## Configuration
- `BHT_STATS_EN` defined:
  - `stat_br_cnt` increments on every `update_en` cycle.
  - `stat_mispred_cnt` increments when `bht_mispred`=1.
  - Both saturate at 32'hFFFF_FFFF and clear on `rst`.
- `BHT_STATS_EN` undefined: both ports are driven to constant 0 and no counter flops are instantiated. All other behaviour is identical.

## Test plan
- Reset, then lookup `PC_IF`=0x0000_0010 -> `bht_hit`=0, `bht_pred_br`=00, `pred_taken`=0.
- Update `PC_EX`=0x10, taken, `bht_hit_EX`=0 -> next cycle lookup 0x10 gives `bht_hit`=1, `bht_pred_br`=10, `pred_taken`=1. Same-cycle `bht_mispred`=1.
- Four more taken updates at 0x10 -> `cnt`=11 (saturates). Then three not-taken updates -> 10, 01, 00 -> `pred_taken`=0. One more not-taken update -> stays 00.
- Aliasing: allocate 0x10, then lookup 0x10 + (1<<(INDEX_LEN+2)) -> `bht_hit`=0. A not-taken update at the aliasing PC leaves the 0x10 entry unchanged.
- Same-cycle: update 0x10 taken (`cnt` 01→10) while `PC_IF`=0x10 -> that cycle reads 01, next cycle reads 10. `rst` asserted with `update_en`=1 -> table empty afterwards.
- With `BHT_STATS_EN`: 5 updates, 2 mispredicted -> `stat_br_cnt`=5, `stat_mispred_cnt`=2. Without the macro, both read 0.
